// File: rtl/usb2_pkg.sv
// Shared USB 2.0 definitions: PID codes, SYNC pattern, CRC16 constants,
// packetizer FSM states and the byte-wide CRC16 step function.
package usb2_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_e;

  localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } tx_state_e;

  // Reflected CRC16, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb2_crc16.sv
// Byte-wide USB CRC16 register; init has priority over enable.
module usb2_crc16
  import usb2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = crc;
    if (init)    crc_nxt = CRC16_INIT;
    else if (en) crc_nxt = crc16_byte(crc, data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc <= CRC16_INIT;
    else     crc <= crc_nxt;
  end

endmodule

// File: rtl/usb2_tx_packetizer.sv
// USB 2.0 TX packetizer: emits SYNC, PID, payload and CRC16 bytes through a
// single holding register under a valid/ready handshake.
module usb2_tx_packetizer
  import usb2_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_PATTERN
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pkt_req,
  input  logic [3:0] i_pid,
  input  logic       i_has_data,
  output logic       o_req_ready,
  input  logic [7:0] i_pl_data,
  input  logic       i_pl_valid,
  input  logic       i_pl_last,
  output logic       o_pl_ready,
  input  logic       i_zlp,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_packet_start,
  output logic       o_packet_end,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_len_err
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);

  tx_state_e   state, state_nxt;
  logic [3:0]  pid_q, pid_nxt;
  logic        has_data_q, has_data_nxt;
  logic        zlp_q, zlp_nxt;
  logic [10:0] cnt_q, cnt_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, start_nxt, end_nxt, len_err_nxt;
  logic        crc_init, crc_en;
  logic [15:0] crc;
  logic        accepted, can_load, pl_take;

  assign accepted    = o_valid && i_ready;
  assign can_load    = !o_valid || i_ready;
  assign o_req_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);
  assign o_pl_ready  = (state == ST_DATA) && can_load;
  assign pl_take     = o_pl_ready && i_pl_valid;

  usb2_crc16 u_crc (
    .clk  (i_clk),
    .rst  (i_rst),
    .init (crc_init),
    .en   (crc_en),
    .data (i_pl_data),
    .crc  (crc)
  );

  always_comb begin
    state_nxt    = state;
    pid_nxt      = pid_q;
    has_data_nxt = has_data_q;
    zlp_nxt      = zlp_q;
    cnt_nxt      = cnt_q;
    data_nxt     = o_data;
    valid_nxt    = o_valid;
    start_nxt    = o_packet_start;
    end_nxt      = o_packet_end;
    len_err_nxt  = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_pkt_req) begin
          pid_nxt      = i_pid;
          has_data_nxt = i_has_data;
          zlp_nxt      = i_zlp;
          cnt_nxt      = '0;
          crc_init     = 1'b1;
          data_nxt     = SYNC_BYTE;
          valid_nxt    = 1'b1;
          start_nxt    = 1'b1;
          end_nxt      = 1'b0;
          state_nxt    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (accepted) begin
          data_nxt  = {~pid_q, pid_q};
          start_nxt = 1'b0;
          end_nxt   = !has_data_q;
          state_nxt = ST_PID;
        end
      end
      ST_PID: begin
        if (accepted) begin
          valid_nxt = 1'b0;
          end_nxt   = 1'b0;
          if (!has_data_q) state_nxt = ST_IDLE;
          else if (zlp_q)  state_nxt = ST_CRC_LO;
          else             state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pl_take) begin
          data_nxt  = i_pl_data;
          valid_nxt = 1'b1;
          crc_en    = 1'b1;
          cnt_nxt   = cnt_q + 11'd1;
          if (i_pl_last) begin
            state_nxt = ST_CRC_LO;
          end else if (cnt_q + 11'd1 == MAX_CNT) begin
            state_nxt   = ST_CRC_LO;
            len_err_nxt = 1'b1;
          end
        end else if (accepted) begin
          valid_nxt = 1'b0;
        end
      end
      // The register may still hold the last payload byte here; CRC_LO waits
      // for room, and CRC_HI uses o_packet_end to tell "lo in flight" from
      // "hi in flight".
      ST_CRC_LO: begin
        if (can_load) begin
          data_nxt  = ~crc[7:0];
          valid_nxt = 1'b1;
          end_nxt   = 1'b0;
          state_nxt = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (accepted) begin
          if (o_packet_end) begin
            valid_nxt = 1'b0;
            end_nxt   = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            data_nxt = ~crc[15:8];
            end_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      pid_q          <= '0;
      has_data_q     <= 1'b0;
      zlp_q          <= 1'b0;
      cnt_q          <= '0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_packet_start <= 1'b0;
      o_packet_end   <= 1'b0;
      o_len_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      pid_q          <= pid_nxt;
      has_data_q     <= has_data_nxt;
      zlp_q          <= zlp_nxt;
      cnt_q          <= cnt_nxt;
      o_data         <= data_nxt;
      o_valid        <= valid_nxt;
      o_packet_start <= start_nxt;
      o_packet_end   <= end_nxt;
      o_len_err      <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_usb2_tx_packetizer.sv
// Directed bench for usb2_tx_packetizer: a MAX_PAYLOAD=64 and a MAX_PAYLOAD=4
// instance share inputs; outputs are muxed by sel for a common monitor.
module tb_usb2_tx_packetizer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       req64, req4;
  logic [3:0] i_pid;
  logic       i_has_data, i_zlp;
  logic [7:0] i_pl_data;
  logic       i_pl_valid, i_pl_last;
  logic       i_ready;

  logic       a_req_ready, a_pl_ready, a_valid, a_start, a_end, a_busy, a_len_err;
  logic [7:0] a_data;
  logic       b_req_ready, b_pl_ready, b_valid, b_start, b_end, b_busy, b_len_err;
  logic [7:0] b_data;

  logic       sel;
  logic       m_req_ready, m_pl_ready, m_valid, m_start, m_end, m_busy, m_len_err;
  logic [7:0] m_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pl [0:63];
  int         cur_n;
  bit         cur_last;
  int         pl_idx;
  int         len_err_cnt;
  logic [7:0] got [$];
  bit         gstart [$];
  bit         gend [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  usb2_tx_packetizer #(.MAX_PAYLOAD(64)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pkt_req(req64), .i_pid(i_pid),
    .i_has_data(i_has_data), .o_req_ready(a_req_ready), .i_pl_data(i_pl_data),
    .i_pl_valid(i_pl_valid), .i_pl_last(i_pl_last), .o_pl_ready(a_pl_ready),
    .i_zlp(i_zlp), .o_data(a_data), .o_valid(a_valid), .o_packet_start(a_start),
    .o_packet_end(a_end), .i_ready(i_ready), .o_busy(a_busy), .o_len_err(a_len_err)
  );

  usb2_tx_packetizer #(.MAX_PAYLOAD(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_pkt_req(req4), .i_pid(i_pid),
    .i_has_data(i_has_data), .o_req_ready(b_req_ready), .i_pl_data(i_pl_data),
    .i_pl_valid(i_pl_valid), .i_pl_last(i_pl_last), .o_pl_ready(b_pl_ready),
    .i_zlp(i_zlp), .o_data(b_data), .o_valid(b_valid), .o_packet_start(b_start),
    .o_packet_end(b_end), .i_ready(i_ready), .o_busy(b_busy), .o_len_err(b_len_err)
  );

  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_pl_ready  = sel ? b_pl_ready  : a_pl_ready;
  assign m_valid     = sel ? b_valid     : a_valid;
  assign m_start     = sel ? b_start     : a_start;
  assign m_end       = sel ? b_end       : a_end;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_len_err   = sel ? b_len_err   : a_len_err;
  assign m_data      = sel ? b_data      : a_data;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Table-free reference: xor the whole byte in, then shift eight times.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic drive_inputs(input bit bp);
    i_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pl_idx < cur_n) begin
      i_pl_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_pl_data  = pl[pl_idx];
      i_pl_last  = cur_last && (pl_idx == cur_n - 1);
    end else begin
      i_pl_valid = 1'b0;
      i_pl_last  = 1'b0;
    end
  endtask

  task automatic run_packet(input string tag, input bit sel4, input logic [3:0] pid,
                            input bit has_data, input bit zlp, input int n_pl,
                            input bit use_last, input bit bp, input int exp_len_err);
    int cyc, maxp, npay, n_s, n_e;
    bit done, prev_stall, prev_s, prev_e;
    logic [7:0] prev_d;
    logic [15:0] c;
    got.delete(); gstart.delete(); gend.delete(); exp_q.delete();
    pl_idx = 0; len_err_cnt = 0; cur_n = n_pl; cur_last = use_last;
    @(posedge clk); #1;
    sel = sel4; i_pid = pid; i_has_data = has_data; i_zlp = zlp;
    if (sel4) req4 = 1'b1; else req64 = 1'b1;
    i_pl_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    check({tag, "_req_ready"}, m_req_ready, 1);
    @(posedge clk); #1;
    req4 = 1'b0; req64 = 1'b0;
    drive_inputs(bp);
    @(negedge clk);
    check({tag, "_first"}, {m_valid, m_start, m_busy, m_data}, {1'b1, 1'b1, 1'b1, 8'h80});
    cyc = 0; done = 0; prev_stall = 0;
    while (1) begin
      if (prev_stall)
        check({tag, "_stall_hold"}, {m_valid, m_start, m_end, m_data},
              {1'b1, prev_s, prev_e, prev_d});
      if (m_len_err) len_err_cnt++;
      if (m_pl_ready && i_pl_valid) pl_idx++;
      if (m_valid && i_ready) begin
        got.push_back(m_data); gstart.push_back(m_start); gend.push_back(m_end);
        if (m_end) done = 1;
      end
      prev_stall = m_valid && !i_ready;
      prev_d = m_data; prev_s = m_start; prev_e = m_end;
      if (done || cyc >= 3000) break;
      @(posedge clk); #1;
      drive_inputs(bp);
      @(negedge clk);
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    i_pl_valid = 1'b0; i_pl_last = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after"}, {m_busy, m_valid, m_req_ready}, {1'b0, 1'b0, 1'b1});

    maxp = sel4 ? 4 : 64;
    exp_q.push_back(8'h80);
    exp_q.push_back({~pid, pid});
    if (has_data) begin
      c = 16'hFFFF;
      npay = zlp ? 0 : ((n_pl < maxp) ? n_pl : maxp);
      for (int i = 0; i < npay; i++) begin
        exp_q.push_back(pl[i]);
        c = ref_crc(c, pl[i]);
      end
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
    check({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    n_s = 0; n_e = 0;
    foreach (gstart[i]) begin n_s += gstart[i]; n_e += gend[i]; end
    if (got.size() > 0)
      check({tag, "_frame"}, {gstart[0], gend[got.size() - 1]}, 2'b11);
    check({tag, "_frame_cnt"}, {n_s[7:0], n_e[7:0]}, {8'd1, 8'd1});
    check({tag, "_len_err"}, len_err_cnt, exp_len_err);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, rev;
    i_rst = 1'b1; req64 = 1'b0; req4 = 1'b0; sel = 1'b0;
    i_pid = '0; i_has_data = 1'b0; i_zlp = 1'b0;
    i_pl_data = '0; i_pl_valid = 1'b0; i_pl_last = 1'b0; i_ready = 1'b1;
    cur_n = 0; cur_last = 0; pl_idx = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", {m_valid, m_start, m_end, m_busy, m_len_err, m_pl_ready, m_req_ready, m_data},
          {7'b0000001, 8'h00});
    @(posedge clk); #1 i_rst = 1'b0;

    run_packet("ack", 0, 4'h2, 0, 0, 0, 0, 0, 0);
    run_packet("zlp", 0, 4'h3, 1, 1, 0, 0, 0, 0);
    check("zlp_crc", {got[2], got[3]}, 16'h0000);

    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    run_packet("d1_123", 0, 4'hB, 1, 0, 9, 1, 0, 0);
    check("d1_crc_bytes", {got[11], got[12]}, 16'hC8B4);
    r = 16'hFFFF;
    for (int i = 2; i < got.size(); i++) r = ref_crc(r, got[i]);
    for (int k = 0; k < 16; k++) rev[k] = r[15 - k];
    check("d1_residual", rev, 16'h800D);

    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
    run_packet("bp64", 0, 4'h3, 1, 0, 64, 1, 1, 0);

    for (int i = 0; i < 6; i++) pl[i] = 8'hA0 + 8'(i);
    run_packet("trunc4", 1, 4'hB, 1, 0, 6, 0, 0, 1);
    check("trunc4_unconsumed", 6 - pl_idx, 2);

    // Reset in the middle of a data packet.
    sel = 1'b0; cur_n = 0;
    @(posedge clk); #1;
    i_pid = 4'hB; i_has_data = 1'b1; i_zlp = 1'b0; req64 = 1'b1;
    @(posedge clk); #1;
    req64 = 1'b0; i_pl_valid = 1'b1; i_pl_data = 8'h55; i_pl_last = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_active", {m_busy, m_valid}, 2'b11);
    i_rst = 1'b1;
    #1;
    check("rst_async", {m_busy, m_valid, m_pl_ready, m_start, m_end, m_req_ready}, 6'b000001);
    i_pl_valid = 1'b0;
    @(posedge clk); #1 i_rst = 1'b0;
    run_packet("ack_after_rst", 0, 4'h2, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb2_tx_packetizer.md
Name: usb2_tx_packetizer

Overview:
Builds complete USB 2.0 packets byte-by-byte in front of the TX serial path (parallel-to-serial, bit stuffer, NRZI, line driver). On a packet request it emits SYNC, the PID byte, the payload bytes and the CRC16 (data packets only). It drives the byte stream plus packet_start/packet_end framing under a valid/ready handshake.

Parameters:
MAX_PAYLOAD, 64, maximum payload bytes per data packet (1..1024)
SYNC_BYTE, 8'h80, SYNC pattern as a byte (LSB first on the wire gives 00000001)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_pkt_req  input  1  request to start a packet; sampled only when o_req_ready=1
i_pid  input  4  PID nibble, captured with the request
i_has_data  input  1  1 = data packet (payload + CRC16), 0 = PID-only handshake packet; captured with the request
o_req_ready  output  1  high in IDLE only
i_pl_data  input  8  payload byte
i_pl_valid  input  1  payload byte valid
i_pl_last  input  1  marks final payload byte
o_pl_ready  output  1  payload byte consumed this cycle when i_pl_valid && o_pl_ready
i_zlp  input  1  with i_has_data=1: zero-length packet, no payload fetched; captured with the request
o_data  output  8  byte to TX path
o_valid  output  1  o_data valid
o_packet_start  output  1  high with the SYNC byte only
o_packet_end  output  1  high with the final byte of the packet
i_ready  input  1  TX path accepts the byte when o_valid && i_ready
o_busy  output  1  high from request acceptance until the final byte has been accepted
o_len_err  output  1  one-cycle pulse when a packet is truncated at MAX_PAYLOAD

Behaviour:
- Reset: o_valid, o_packet_start, o_packet_end, o_busy, o_len_err, o_pl_ready are 0. o_data is 8'h00. o_req_ready is 1. FSM is in IDLE and CRC = 16'hFFFF. Reset asserted mid-packet clears all outputs immediately, with no EOP.
- The output byte register holds o_data, o_valid and the framing bits stable until accepted. Nothing changes while o_valid && !i_ready.
- FSM states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI.
- IDLE: i_pkt_req=1 in cycle N latches pid, has_data and zlp, and goes to SYNC. SYNC_BYTE is presented with o_valid=1 and o_packet_start=1 in cycle N+1.
- SYNC accepted -> PID. PID byte = {~pid, pid}. o_packet_end=1 on the PID byte if has_data=0.
- PID accepted: has_data=0 -> IDLE. zlp=1 -> CRC_LO. Otherwise -> DATA.
- DATA: o_pl_ready = !o_valid || i_ready, so the byte register is refilled in the same cycle it drains.
  - A payload byte taken loads the output register, updates the CRC and increments the 11-bit byte count.
  - No input byte available: o_valid drops to 0. This is a stall; upstream must pre-buffer because the line cannot underrun.
  - Byte taken with i_pl_last=1 -> CRC_LO.
  - Count reaches MAX_PAYLOAD without i_pl_last: go to CRC_LO, pulse o_len_err, drop o_pl_ready. Remaining upstream bytes are not consumed by this block.
- CRC16 (USB): reflected polynomial 0xA001, init 16'hFFFF, processed LSB first over payload bytes only (not the PID). Transmitted value = ~crc.
- CRC_LO sends ~crc[7:0]. CRC_HI sends ~crc[15:8] with o_packet_end=1, then -> IDLE. The CRC is reinitialised on entry to SYNC.
- Zero-length packet: CRC bytes are 8'h00, 8'h00.
- A new request is accepted in the cycle after the final byte's acceptance, since o_req_ready returns with IDLE. Back-to-back packets are allowed, with no bubble constraint beyond that.
- i_pkt_req outside IDLE is ignored. i_pl_valid outside DATA is ignored (o_pl_ready=0).
- Simultaneous i_pl_last=1 and count reaching MAX_PAYLOAD: this is a legal full-length packet and o_len_err is not pulsed.

Decomposition:
- Shared package usb2_pkg: PID enum (OUT=4'h1, IN=4'h9, SOF=4'h5, SETUP=4'hD, DATA0=4'h3, DATA1=4'hB, ACK=4'h2, NAK=4'hA, STALL=4'hE), SYNC constant, CRC16 polynomial/init/residual (16'h800D) constants, FSM state typedef.
- Sub-module usb2_crc16: byte-wide combinational next-state function plus register, with init/enable inputs. The RX CRC checker reuses it.

Test Plan:
- ACK request (pid=4'h2, has_data=0), i_ready=1 always -> bytes 80, D2 with start on 80 and end on D2; o_busy falls after D2.
- DATA0 ZLP (pid=4'h3, zlp=1) -> 80, C3, 00, 00, with end on the last 00.
- DATA1 payload ASCII "123456789" (31..39, last on 39) -> 80, 4B, 31..39, C8, B4. Running the receiver-side CRC over payload plus CRC gives residual 16'h800D.
- Random i_ready backpressure and i_pl_valid gaps on a 64-byte packet -> byte order unchanged, o_data stable while stalled, exactly 68 accepted bytes, CRC matches the golden model.
- MAX_PAYLOAD=4, upstream supplies 6 bytes with no last -> 4 payload bytes sent, o_len_err pulses once, CRC over 4 bytes, 2 bytes left unconsumed.
- i_rst asserted during DATA -> o_valid/o_busy low asynchronously. After release, an ACK request produces a clean 80, D2 packet.
